// File: rtl/soc_miner_fetch_if.sv
// Bundles the command, AXI3 read-channel and output-stream signals of the fetch stage.
// The master modport is the fetch block; slave is the surrounding system.
interface soc_miner_fetch_if #(
  parameter int MEMORY_DATA_WIDTH    = 64,
  parameter int MEMORY_ADDR_WIDTH    = 32,
  parameter int MEMORY_BUS_LEN_WIDTH = 4,
  parameter int MEMORY_ID_WIDTH      = 6
);
  logic                            cmd_valid;
  logic                            cmd_ready;
  logic [MEMORY_ADDR_WIDTH-1:0]    cmd_addr;
  logic [15:0]                     cmd_len;

  logic                            m_memory_arvalid;
  logic                            m_memory_arready;
  logic [MEMORY_ADDR_WIDTH-1:0]    m_memory_araddr;
  logic [MEMORY_BUS_LEN_WIDTH-1:0] m_memory_arlen;
  logic [MEMORY_ID_WIDTH-1:0]      m_memory_arid;
  logic [2:0]                      m_memory_arsize;
  logic [1:0]                      m_memory_arburst;
  logic [1:0]                      m_memory_arlock;
  logic [3:0]                      m_memory_arcache;
  logic [2:0]                      m_memory_arprot;
  logic [3:0]                      m_memory_arqos;

  logic                            m_memory_rvalid;
  logic                            m_memory_rready;
  logic [MEMORY_DATA_WIDTH-1:0]    m_memory_rdata;
  logic                            m_memory_rlast;
  logic [1:0]                      m_memory_rresp;
  logic [MEMORY_ID_WIDTH-1:0]      m_memory_rid;

  logic                            out_valid;
  logic                            out_ready;
  logic [MEMORY_DATA_WIDTH-1:0]    out_data;
  logic                            out_last;

  logic                            busy;
  logic                            done;
  logic                            error;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len,
    output cmd_ready,
    output m_memory_arvalid, m_memory_araddr, m_memory_arlen, m_memory_arid,
    output m_memory_arsize, m_memory_arburst, m_memory_arlock, m_memory_arcache,
    output m_memory_arprot, m_memory_arqos,
    input  m_memory_arready,
    input  m_memory_rvalid, m_memory_rdata, m_memory_rlast, m_memory_rresp, m_memory_rid,
    output m_memory_rready,
    output out_valid, out_data, out_last,
    input  out_ready,
    output busy, done, error
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len,
    input  cmd_ready,
    input  m_memory_arvalid, m_memory_araddr, m_memory_arlen, m_memory_arid,
    input  m_memory_arsize, m_memory_arburst, m_memory_arlock, m_memory_arcache,
    input  m_memory_arprot, m_memory_arqos,
    output m_memory_arready,
    output m_memory_rvalid, m_memory_rdata, m_memory_rlast, m_memory_rresp, m_memory_rid,
    input  m_memory_rready,
    input  out_valid, out_data, out_last,
    output out_ready,
    input  busy, done, error
  );
endinterface

// File: rtl/soc_miner_fetch.sv
// Read-DMA front end for the mining core: splits a beat-count command into 4 KB-safe
// AXI3 INCR bursts (one outstanding) and streams the returned beats through a local FIFO.
module soc_miner_fetch #(
  parameter int MEMORY_DATA_WIDTH    = 64,
  parameter int MEMORY_ADDR_WIDTH    = 32,
  parameter int MEMORY_BUS_LEN_WIDTH = 4,
  parameter int MEMORY_ID_WIDTH      = 6,
  parameter int FIFO_DEPTH           = 32,
  parameter int FETCH_ID             = 0
) (
  input logic               Clk,
  input logic               Rst_n,
  soc_miner_fetch_if.master bus
);
  localparam int DW = MEMORY_DATA_WIDTH;
  localparam int AW = MEMORY_ADDR_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, RESP, FLUSH} state_t;

  state_t          r_state, w_next;
  logic [AW-1:0]   r_addr;
  logic [15:0]     r_rem;
  logic [4:0]      r_blen, r_beat;
  logic            r_error, r_done;
  logic [DW:0]     r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wp, r_rp;
  logic [PW:0]     r_cnt;

  logic            w_cmd_ready, w_arvalid, w_rready;
  logic [9:0]      w_page;
  logic [4:0]      w_blen, w_blen_m1;
  logic [PW:0]     w_free;
  logic            w_credit, w_full, w_out_valid, w_out_last;
  logic            w_rbeat, w_pop, w_burst_last, w_tag_last, w_ar_hs;
  logic            w_unused;

  // Beats left before the next 4 KB page boundary (1..512).
  assign w_page = 10'd512 - {1'b0, r_addr[11:3]};

  always_comb begin
    w_blen = 5'd16;
    if (r_rem < 16'd16) w_blen = r_rem[4:0];
    if (w_page < {5'd0, w_blen}) w_blen = w_page[4:0];
  end

  assign w_blen_m1    = w_blen - 5'd1;
  assign w_free       = (PW+1)'(FIFO_DEPTH) - r_cnt;
  assign w_credit     = w_free >= (PW+1)'(w_blen);
  assign w_full       = r_cnt == (PW+1)'(FIFO_DEPTH);
  assign w_out_valid  = r_cnt != '0;
  assign w_out_last   = w_out_valid & r_mem[r_rp][DW];
  assign w_pop        = w_out_valid & bus.out_ready;
  assign w_rbeat      = bus.m_memory_rvalid & w_rready;
  assign w_ar_hs      = w_arvalid & bus.m_memory_arready;
  assign w_burst_last = (r_beat + 5'd1) == r_blen;
  // Remaining count is decremented at AR time, so zero here means this is the job's final burst.
  assign w_tag_last   = w_burst_last & (r_rem == 16'd0);
  assign w_unused     = ^{bus.m_memory_rid, bus.cmd_addr[2:0]};

  always_ff @(posedge Clk) begin
    if (!Rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_cmd_ready = 1'b0;
    w_arvalid   = 1'b0;
    w_rready    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid && bus.cmd_len != 16'd0) w_next = REQ;
      end
      REQ: begin
        w_arvalid = w_credit;
        if (w_credit && bus.m_memory_arready) w_next = RESP;
      end
      RESP: begin
        // A pop on a full FIFO frees the slot in the same cycle.
        w_rready = !w_full || bus.out_ready;
        if (bus.m_memory_rvalid && w_rready && w_burst_last)
          w_next = (r_rem != 16'd0) ? REQ : FLUSH;
      end
      FLUSH: if (w_pop && w_out_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_addr  <= '0;
      r_rem   <= '0;
      r_blen  <= '0;
      r_beat  <= '0;
      r_error <= 1'b0;
      r_done  <= 1'b0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE && bus.cmd_valid) begin
        r_addr  <= {bus.cmd_addr[AW-1:3], 3'b000};
        r_rem   <= bus.cmd_len;
        r_error <= 1'b0;
        if (bus.cmd_len == 16'd0) r_done <= 1'b1;
      end
      if (w_ar_hs) begin
        r_addr <= r_addr + AW'({w_blen, 3'b000});
        r_rem  <= r_rem - 16'(w_blen);
        r_blen <= w_blen;
        r_beat <= '0;
      end
      if (w_rbeat) begin
        r_beat <= r_beat + 5'd1;
        if (bus.m_memory_rresp != 2'b00 || bus.m_memory_rlast != w_burst_last) r_error <= 1'b1;
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      if (w_rbeat && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_rbeat && w_pop) r_cnt <= r_cnt - 1'b1;
      if (r_state == FLUSH && w_pop && w_out_last) r_done <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (w_rbeat) r_mem[r_wp] <= {w_tag_last, bus.m_memory_rdata};
  end

  assign bus.cmd_ready        = w_cmd_ready;
  assign bus.m_memory_arvalid = w_arvalid;
  assign bus.m_memory_araddr  = r_addr;
  assign bus.m_memory_arlen   = (r_state == REQ) ? MEMORY_BUS_LEN_WIDTH'(w_blen_m1) : '0;
  assign bus.m_memory_arid    = MEMORY_ID_WIDTH'(FETCH_ID);
  assign bus.m_memory_arsize  = 3'b011;
  assign bus.m_memory_arburst = 2'b01;
  assign bus.m_memory_arlock  = 2'b00;
  assign bus.m_memory_arcache = 4'b0011;
  assign bus.m_memory_arprot  = 3'b000;
  assign bus.m_memory_arqos   = 4'b0000;
  assign bus.m_memory_rready  = w_rready;
  assign bus.out_valid        = w_out_valid;
  assign bus.out_data         = r_mem[r_rp][DW-1:0];
  assign bus.out_last         = w_out_last;
  assign bus.busy             = r_state != IDLE;
  assign bus.done             = r_done;
  assign bus.error            = r_error;
endmodule

// File: tb/tb_soc_miner_fetch.sv
// Directed bench for soc_miner_fetch: a behavioural AXI read slave with an address-derived
// data pattern, a table of jobs with hand-computed AR sequences, and corner-case sequences.
module tb_soc_miner_fetch;
  logic Clk = 1'b0;
  logic Rst_n;
  always #5 Clk = ~Clk;

  soc_miner_fetch_if bus ();
  soc_miner_fetch dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));

  typedef struct {
    logic [31:0] addr;
    logic [15:0] len;
    int          nar;
    logic [31:0] a [4];
    logic [3:0]  l [4];
  } vec_t;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  // slave model state
  logic        s_act = 1'b0;
  logic [31:0] s_addr = '0;
  int          s_left = 0, s_gbeat = 0, err_beat = -1;
  // logs
  logic [31:0] ar_aq [$];
  logic [3:0]  ar_lq [$];
  logic [63:0] rx_d [$];
  logic        rx_l [$];
  int n_rbeats = 0, n_done = 0, done_cyc = 0, last_cyc = 0, acc_cyc = 0;
  logic done_rdy = 1'b0, got_acc = 1'b0;

  function automatic logic [63:0] pat(logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Runs one clock: drive slave outputs, sample handshakes just before the edge, update at negedge.
  task automatic tick();
    logic f_acc, f_ar, f_r, f_o, o_l;
    logic [31:0] ar_a;
    logic [3:0]  ar_l;
    logic [63:0] o_d;
    bus.m_memory_arready = 1'b1;
    bus.m_memory_rvalid  = s_act;
    bus.m_memory_rdata   = pat(s_addr);
    bus.m_memory_rlast   = (s_left == 1);
    bus.m_memory_rresp   = (s_gbeat == err_beat) ? 2'b10 : 2'b00;
    #1;
    f_acc = bus.cmd_valid & bus.cmd_ready;
    f_ar  = bus.m_memory_arvalid & bus.m_memory_arready;
    ar_a  = bus.m_memory_araddr;
    ar_l  = bus.m_memory_arlen;
    f_r   = bus.m_memory_rvalid & bus.m_memory_rready;
    f_o   = bus.out_valid & bus.out_ready;
    o_d   = bus.out_data;
    o_l   = bus.out_last;
    if (bus.done) begin n_done++; done_cyc = cyc; done_rdy = bus.cmd_ready; end
    if (f_acc) begin got_acc = 1'b1; acc_cyc = cyc; end
    if (f_o && o_l) last_cyc = cyc;
    @(negedge Clk);
    cyc++;
    if (!Rst_n) s_act = 1'b0;
    else begin
      if (f_ar) begin
        ar_aq.push_back(ar_a); ar_lq.push_back(ar_l);
        s_act = 1'b1; s_addr = ar_a; s_left = int'(ar_l) + 1;
      end
      if (f_r) begin
        s_addr += 8; s_left--; s_gbeat++; n_rbeats++;
        if (s_left == 0) s_act = 1'b0;
      end
      if (f_o) begin rx_d.push_back(o_d); rx_l.push_back(o_l); end
    end
  endtask

  task automatic start_job(logic [31:0] a, logic [15:0] l);
    ar_aq.delete(); ar_lq.delete(); rx_d.delete(); rx_l.delete();
    n_rbeats = 0; n_done = 0; s_gbeat = 0; got_acc = 1'b0;
    bus.cmd_addr = a; bus.cmd_len = l; bus.cmd_valid = 1'b1;
    for (int i = 0; i < 10 && !got_acc; i++) tick();
    bus.cmd_valid = 1'b0;
    chk("accept", got_acc, 1'b1);
  endtask

  task automatic wait_done(int budget);
    for (int i = 0; i < budget && n_done == 0; i++) tick();
    tick(); tick();
  endtask

  task automatic check_job(vec_t v, logic exp_err);
    int bad;
    logic [31:0] base;
    chk("ar_count", ar_aq.size(), v.nar);
    for (int i = 0; i < v.nar && i < ar_aq.size(); i++) begin
      chk("araddr", ar_aq[i], v.a[i]);
      chk("arlen", ar_lq[i], v.l[i]);
    end
    chk("beats", rx_d.size(), v.len);
    bad = 0;
    base = v.addr & ~32'h7;
    for (int i = 0; i < rx_d.size(); i++) begin
      if (rx_d[i] !== pat(base + 32'(i) * 8)) bad++;
      if (rx_l[i] !== (i == int'(v.len) - 1)) bad++;
    end
    chk("data_last", bad, 0);
    chk("done_pulses", n_done, 1);
    chk("done_latency", done_cyc, (v.len == 0) ? acc_cyc + 1 : last_cyc + 1);
    chk("done_cmd_ready", done_rdy, 1'b1);
    chk("error", bus.error, exp_err);
    chk("busy_after", bus.busy, 1'b0);
  endtask

  vec_t vt [6];
  vec_t vx;

  initial begin
    vt[0] = '{32'h1000_0000, 16'd16, 1, '{32'h1000_0000, 0, 0, 0}, '{4'd15, 0, 0, 0}};
    vt[1] = '{32'h1000_0FC0, 16'd20, 2, '{32'h1000_0FC0, 32'h1000_1000, 0, 0}, '{4'd7, 4'd11, 0, 0}};
    vt[2] = '{32'h2000_0003, 16'd5,  1, '{32'h2000_0000, 0, 0, 0}, '{4'd4, 0, 0, 0}};
    vt[3] = '{32'h3000_0FF8, 16'd3,  2, '{32'h3000_0FF8, 32'h3000_1000, 0, 0}, '{4'd0, 4'd1, 0, 0}};
    vt[4] = '{32'h4000_0000, 16'd40, 3, '{32'h4000_0000, 32'h4000_0080, 32'h4000_0100, 0},
              '{4'd15, 4'd15, 4'd7, 0}};
    vt[5] = '{32'h8000_0000, 16'd0,  0, '{0, 0, 0, 0}, '{0, 0, 0, 0}};

    Rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.m_memory_arready = 1'b1; bus.m_memory_rvalid = 1'b0; bus.m_memory_rdata = '0;
    bus.m_memory_rlast = 1'b0; bus.m_memory_rresp = 2'b00; bus.m_memory_rid = '0;
    bus.out_ready = 1'b1;
    @(negedge Clk);
    tick(); tick();
    Rst_n = 1'b1;
    tick();

    chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk("rst_ar", {bus.m_memory_arvalid, bus.m_memory_araddr, bus.m_memory_arlen}, '0);
    chk("rst_rready", bus.m_memory_rready, 1'b0);
    chk("rst_out", {bus.out_valid, bus.out_last}, 2'b00);
    chk("rst_status", {bus.busy, bus.done, bus.error}, 3'b000);
    chk("ar_consts", {bus.m_memory_arid, bus.m_memory_arsize, bus.m_memory_arburst, bus.m_memory_arlock,
                      bus.m_memory_arcache, bus.m_memory_arprot, bus.m_memory_arqos},
        {6'd0, 3'b011, 2'b01, 2'b00, 4'b0011, 3'b000, 4'b0000});

    for (int k = 0; k < 6; k++) begin
      start_job(vt[k].addr, vt[k].len);
      wait_done(400);
      check_job(vt[k], 1'b0);
    end

    // Backpressure: FIFO fills with two bursts, third AR must wait for credit.
    bus.out_ready = 1'b0;
    start_job(32'h5000_0000, 16'd64);
    for (int i = 0; i < 150; i++) tick();
    chk("bp_ar_count", ar_aq.size(), 2);
    chk("bp_rbeats", n_rbeats, 32);
    chk("bp_rready", bus.m_memory_rready, 1'b0);
    chk("bp_arvalid", bus.m_memory_arvalid, 1'b0);
    chk("bp_out_valid", bus.out_valid, 1'b1);
    bus.out_ready = 1'b1;
    wait_done(400);
    vx = '{32'h5000_0000, 16'd64, 4, '{32'h5000_0000, 32'h5000_0080, 32'h5000_0100, 32'h5000_0180},
           '{4'd15, 4'd15, 4'd15, 4'd15}};
    check_job(vx, 1'b0);

    // SLVERR on the third beat: error sticks past done, cleared by next acceptance.
    err_beat = 2;
    start_job(32'h6000_0000, 16'd16);
    wait_done(200);
    vx = '{32'h6000_0000, 16'd16, 1, '{32'h6000_0000, 0, 0, 0}, '{4'd15, 0, 0, 0}};
    check_job(vx, 1'b1);
    tick(); tick();
    chk("err_sticky", bus.error, 1'b1);
    err_beat = -1;
    start_job(32'h6000_1000, 16'd0);
    chk("err_cleared", bus.error, 1'b0);
    wait_done(20);

    // Reset in the middle of a burst, then a normal job.
    start_job(32'h7000_0000, 16'd32);
    for (int i = 0; i < 60 && n_rbeats < 5; i++) tick();
    chk("mid_rbeats", n_rbeats >= 5, 1'b1);
    Rst_n = 1'b0;
    tick();
    chk("mrst_ar_r", {bus.m_memory_arvalid, bus.m_memory_rready}, 2'b00);
    chk("mrst_out_busy", {bus.out_valid, bus.busy}, 2'b00);
    chk("mrst_cmd_ready", bus.cmd_ready, 1'b1);
    Rst_n = 1'b1;
    tick();
    start_job(vt[0].addr, vt[0].len);
    wait_done(200);
    check_job(vt[0], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/soc_miner_fetch.md
# soc_miner_fetch

Read-DMA stage that sits directly upstream of the mining core on the HP0 memory path. It takes a (start address, beat count) command from the control logic and issues AXI3 INCR read bursts on the `m_memory_*` read channels, which connect to the PS HP0 slave port. It buffers the returned 64-bit beats in a local FIFO and presents them to the core as a valid/ready stream with an end-of-job marker.

## Interface
- MEMORY_DATA_WIDTH, 64, R data and stream width; beat = 8 bytes
- MEMORY_ADDR_WIDTH, 32, byte address width
- MEMORY_BUS_LEN_WIDTH, 4, ARLEN width; max burst 16 beats
- MEMORY_ID_WIDTH, 6, ARID/RID width
- FIFO_DEPTH, 32, beat buffer depth, power of 2, ≥16
- FETCH_ID, 0, constant ARID value

- Clk  in  1  single clock, rising edge
- Rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE only
- cmd_addr  in  MEMORY_ADDR_WIDTH  start byte address, bits [2:0] ignored (forced 0)
- cmd_len  in  16  beats to fetch, 0 allowed
- m_memory_arvalid/arready  out/in  1  AR handshake
- m_memory_araddr  out  MEMORY_ADDR_WIDTH  burst address
- m_memory_arlen  out  MEMORY_BUS_LEN_WIDTH  beats−1
- m_memory_arid  out  MEMORY_ID_WIDTH  = FETCH_ID
- m_memory_arsize/arburst/arlock/arcache/arprot/arqos  out  3/2/2/4/3/4  constants 3'b011, 2'b01, 0, 4'b0011, 0, 0
- m_memory_rvalid/rready  in/out  1  R handshake
- m_memory_rdata  in  MEMORY_DATA_WIDTH  read beat
- m_memory_rlast  in  1  last beat of burst
- m_memory_rresp  in  2  response
- m_memory_rid  in  MEMORY_ID_WIDTH  ignored
- out_valid/out_ready  out/in  1  stream handshake to core
- out_data  out  MEMORY_DATA_WIDTH  beat
- out_last  out  1  final beat of command
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at job end
- error  out  1  sticky; cleared on next command acceptance

## Operation
- States: IDLE, REQ, RESP, FLUSH.
- IDLE: cmd_ready=1. On cmd_valid, latch addr/len and clear error.
  - len≠0: go to REQ.
  - len=0: pulse done next cycle, stay IDLE, no AR.
- REQ: compute burst length `blen = min(remaining, 16, (4096 − addr[11:0])/8)`. Bursts never cross a 4 KB boundary.
  - Assert arvalid only when FIFO free entries ≥ blen.
  - araddr/arlen are stable while arvalid=1.
  - On arready: go to RESP, then `addr += blen*8`, `remaining −= blen`.
- RESP: rready = FIFO not full. Each accepted beat is pushed to the FIFO, tagged out_last if it is the command's final beat.
  - rresp≠OKAY sets error.
  - rlast on the wrong beat, or missing on the expected last beat, sets error. The beat count (not rlast) terminates the burst.
  - After the last burst beat: go to REQ if remaining≠0, else FLUSH.
- FLUSH: wait until the out_last beat is taken (out_valid & out_ready & out_last). Then pulse done and go to IDLE.
- Single outstanding burst. Data beats are forwarded even on error.
- busy = state≠IDLE.

## Timing
- Reset values: cmd_ready=1 (from first cycle after reset), arvalid=0, rready=0, out_valid=0, out_last=0, busy=0, done=0, error=0, araddr=0, arlen=0. FIFO is emptied.
- Reset mid-operation discards all state and buffered data. The PS shares the reset, so in-flight AXI transactions are abandoned.
- arvalid rises the cycle after command acceptance (or after FIFO credit becomes available).
- Next AR is issued no earlier than the cycle after the previous burst's final R beat.
- FIFO is registered: out_valid rises the cycle after an R beat is accepted. Sustains 1 beat/cycle when out_ready=1.
- Simultaneous FIFO push and pop on full is allowed; count is unchanged.
- done asserts the cycle after the out_last handshake; cmd_ready=1 in that same cycle.
- cmd_len=0: done asserts the cycle after acceptance.

## Test plan
- cmd_addr=0x1000_0000, cmd_len=16, out_ready=1 → one AR with araddr=0x1000_0000, arlen=15; 16 out beats in order; out_last on beat 16; done one cycle later.
- cmd_addr=0x1000_0FC0, cmd_len=20 → AR1 araddr=0x1000_0FC0, arlen=7; AR2 araddr=0x1000_1000, arlen=11; 20 beats; single out_last.
- cmd_len=0 → no arvalid; done pulses the cycle after acceptance; error=0.
- cmd_len=64, out_ready=0 → exactly 32 beats buffered; no third AR; rready low once full. Raise out_ready → remaining bursts issue; all 64 beats delivered in order.
- rresp=SLVERR on beat 3 of a 16-beat job → error=1 and stays 1 after done; all 16 beats delivered. Next command acceptance clears error.
- Rst_n low during RESP of a 32-beat job → next cycle arvalid=0, rready=0, out_valid=0, busy=0, cmd_ready=1. A new 16-beat command then completes normally.
